// File: rtl/glip_stream_tester.sv
`default_nettype none
// ============================================================================
//  Module      : glip_stream_tester
//  Description : Stream loopback tester. It generates an incrementing word
//                sequence on the Logic->Host port and checks that the
//                Host->Logic port delivers a contiguous incrementing
//                sequence. It also counts transfers and sequence errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module glip_stream_tester #(
  parameter int WIDTH = 16,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [31:0]      tx_count,
  output logic [31:0]      rx_count,
  output logic [ERR_W-1:0] err_count,
  output logic             err_flag,
  output logic             locked
);

  localparam logic [WIDTH-1:0] c_data_one = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] c_err_one  = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] c_err_max  = {ERR_W{1'b1}};

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Generator state
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;

  // Sink-side accept, raised once after reset release
  logic             in_ready_q;

  // Checker and statistics state
  state_t           state_q,     state_d;
  logic [WIDTH-1:0] expected_q,  expected_d;
  logic [31:0]      tx_count_q,  tx_count_d;
  logic [31:0]      rx_count_q,  rx_count_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             err_flag_q,  err_flag_d;
  logic             locked_q,    locked_d;

  logic             out_xfer;
  logic             in_xfer;

  assign out_xfer = out_valid_q && out_ready;
  assign in_xfer  = in_valid && in_ready_q;

  // Generator next state: a pending word is never retracted; after a
  // transfer the next word is offered only while enable is still high.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_xfer) begin
      out_data_d  = out_data_q + c_data_one;
      out_valid_d = enable;
    end else if (!out_valid_q) begin
      out_valid_d = enable;
    end
  end

  // Generator registers; clear deliberately has no effect here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // in_ready leaves reset low and rises on the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q <= 1'b0;
    end else begin
      in_ready_q <= 1'b1;
    end
  end

  // Checker next state and statistics; clear overrides any transfer
  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    tx_count_d  = tx_count_q;
    rx_count_d  = rx_count_q;
    err_count_d = err_count_q;
    err_flag_d  = err_flag_q;
    if (clear) begin
      state_d     = HUNT;
      tx_count_d  = '0;
      rx_count_d  = '0;
      err_count_d = '0;
      err_flag_d  = 1'b0;
    end else begin
      if (out_xfer) begin
        tx_count_d = tx_count_q + 32'd1;
      end
      if (in_xfer) begin
        rx_count_d = rx_count_q + 32'd1;
        case (state_q)
          HUNT: begin
            expected_d = in_data + c_data_one;
            state_d    = LOCKED;
          end
          LOCKED: begin
            if (in_data == expected_q) begin
              expected_d = expected_q + c_data_one;
            end else begin
              // Resynchronise on the received word so a single slip
              // costs a single error
              expected_d = in_data + c_data_one;
              err_flag_d = 1'b1;
              if (err_count_q != c_err_max) begin
                err_count_d = err_count_q + c_err_one;
              end
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
    locked_d = (state_d == LOCKED);
  end

  // Checker FSM and statistics registers with registered locked output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      expected_q  <= '0;
      tx_count_q  <= '0;
      rx_count_q  <= '0;
      err_count_q <= '0;
      err_flag_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      tx_count_q  <= tx_count_d;
      rx_count_q  <= rx_count_d;
      err_count_q <= err_count_d;
      err_flag_q  <= err_flag_d;
      locked_q    <= locked_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign in_ready  = in_ready_q;
  assign tx_count  = tx_count_q;
  assign rx_count  = rx_count_q;
  assign err_count = err_count_q;
  assign err_flag  = err_flag_q;
  assign locked    = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_glip_stream_tester.sv
`default_nettype none
// ============================================================================
//  Module      : tb_glip_stream_tester
//  Description : Directed self-checking bench for glip_stream_tester
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_glip_stream_tester;

  localparam int WIDTH = 16;
  localparam int ERR_W = 16;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             clear;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [31:0]      tx_count;
  logic [31:0]      rx_count;
  logic [ERR_W-1:0] err_count;
  logic             err_flag;
  logic             locked;

  int n_checks;
  int n_errors;

  glip_stream_tester #(
    .WIDTH (WIDTH),
    .ERR_W (ERR_W)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .clear     (clear),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .tx_count  (tx_count),
    .rx_count  (rx_count),
    .err_count (err_count),
    .err_flag  (err_flag),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off-edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word on the checker input for one cycle
  task automatic send(input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  logic [WIDTH-1:0] gen_model;
  int               wrap_seen;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    enable    = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {16'd0, out_data},  32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_tx_count",  tx_count,           32'd0);
    check("rst_rx_count",  rx_count,           32'd0);
    check("rst_err_count", {16'd0, err_count}, 32'd0);
    check("rst_err_flag",  {31'd0, err_flag},  32'd0);
    check("rst_locked",    {31'd0, locked},    32'd0);

    // Release reset away from the edge, then run the generator
    #3;
    rst_n     = 1'b1;
    enable    = 1'b1;
    out_ready = 1'b1;
    tick();
    check("in_ready_after_release", {31'd0, in_ready}, 32'd1);
    check("first_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("seq_word%0d", i), {16'd0, out_data}, i);
      tick();
    end
    check("tx_count_5", tx_count, 32'd5);

    // Stall with word 7 pending
    tick();
    tick();
    check("pending_7", {16'd0, out_data}, 32'd7);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_data",  {16'd0, out_data},  32'd7);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    check("after_stall", {16'd0, out_data}, 32'd8);

    // Disable with word 8 pending: no retraction
    enable    = 1'b0;
    out_ready = 1'b0;
    tick();
    check("no_retract_valid", {31'd0, out_valid}, 32'd1);
    check("no_retract_data",  {16'd0, out_data},  32'd8);
    out_ready = 1'b1;
    tick();
    check("drop_after_xfer", {31'd0, out_valid}, 32'd0);
    check("next_word_9",     {16'd0, out_data},  32'd9);
    tick();
    check("stays_idle", {31'd0, out_valid}, 32'd0);

    // Re-enable continues at 9
    out_ready = 1'b0;
    enable    = 1'b1;
    tick();
    check("reenable_valid", {31'd0, out_valid}, 32'd1);
    check("reenable_data",  {16'd0, out_data},  32'd9);
    enable = 1'b0;

    // Checker: 10,11,12,20,21
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_rx",     rx_count,          32'd0);
    check("clr_tx",     tx_count,          32'd0);
    check("clr_locked", {31'd0, locked},   32'd0);
    send(16'd10);
    check("lock_after_10", {31'd0, locked},    32'd1);
    check("err_after_10",  {16'd0, err_count}, 32'd0);
    send(16'd11);
    send(16'd12);
    check("err_after_12", {16'd0, err_count}, 32'd0);
    send(16'd20);
    check("err_after_20",  {16'd0, err_count}, 32'd1);
    check("flag_after_20", {31'd0, err_flag},  32'd1);
    check("lock_after_20", {31'd0, locked},    32'd1);
    send(16'd21);
    check("err_after_21", {16'd0, err_count}, 32'd1);
    check("rx_after_5",   rx_count,           32'd5);
    tick();
    check("rx_idle", rx_count, 32'd5);

    // Clear in the same cycle as a transfer: clear wins
    in_valid = 1'b1;
    in_data  = 16'd99;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clrx_rx",     rx_count,           32'd0);
    check("clrx_locked", {31'd0, locked},    32'd0);
    check("clrx_err",    {16'd0, err_count}, 32'd0);
    check("clrx_flag",   {31'd0, err_flag},  32'd0);
    send(16'd5);
    check("relock_5",     {31'd0, locked},    32'd1);
    check("relock_err",   {16'd0, err_count}, 32'd0);
    send(16'd6);
    check("relock_6_err", {16'd0, err_count}, 32'd0);

    // Checker wrap: expecting FFFF, receives FFFF then 0000
    clear = 1'b1;
    tick();
    clear = 1'b0;
    send(16'hFFFE);
    send(16'hFFFF);
    send(16'h0000);
    check("wrap_chk_err", {16'd0, err_count}, 32'd0);
    check("wrap_chk_rx",  rx_count,           32'd3);
    check("wrap_chk_gen_held", {16'd0, out_data}, 32'd9);

    // Error flood while the generator free-runs through its wrap.
    // The clear cycle transfers word 9 uncounted; then 70001 transfers.
    clear     = 1'b1;
    enable    = 1'b1;
    out_ready = 1'b1;
    tick();
    clear     = 1'b0;
    check("flood_start_data", {16'd0, out_data}, 32'd10);
    check("flood_start_tx",   tx_count,          32'd0);
    gen_model = 16'd10;
    wrap_seen = 0;
    in_valid  = 1'b1;
    in_data   = 16'd5;
    for (int i = 0; i < 70001; i++) begin
      tick();
      gen_model = gen_model + 16'd1;
      if (gen_model == 16'h0000) begin
        wrap_seen++;
        check("gen_wrap_to_0", {16'd0, out_data}, 32'd0);
      end
    end
    check("gen_wrap_seen",   wrap_seen,          32'd1);
    check("sat_err_count",   {16'd0, err_count}, 32'd65535);
    check("sat_err_flag",    {31'd0, err_flag},  32'd1);
    for (int i = 0; i < 10; i++) tick();
    in_valid = 1'b0;
    check("sat_err_hold",    {16'd0, err_count}, 32'd65535);
    check("flood_rx_count",  rx_count,           32'd70011);
    check("flood_tx_count",  tx_count,           32'd70011);
    check("flood_gen_data",  {16'd0, out_data},  32'd4485);

    // Reset mid-transfer discards pending word
    out_ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_data",  {16'd0, out_data},  32'd0);
    check("midrst_ready", {31'd0, in_ready},  32'd0);
    check("midrst_tx",    tx_count,           32'd0);
    tick();
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    check("restart_valid", {31'd0, out_valid}, 32'd1);
    check("restart_data",  {16'd0, out_data},  32'd0);
    tick();
    check("restart_next",  {16'd0, out_data},  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
